periph_joypad: RTL and testbench

- Peripheral-side responder on the peripheral bus: the target end of periphbus transactions for the two controller ports ($4016/$4017).
- Drives the serial controller pads (latch/clock) and captures 8 button bits per pad.
- Presents them to the CPU as NES-style serial read registers.
- Sits beside the APU/IO peripherals, selected by the peripheral address decoder.

---
 rtl/periph_joypad_pkg.sv | 21 ++
 rtl/periph_joypad_if.sv | 13 +
 rtl/periph_joypad_shift.sv | 43 ++++
 rtl/periph_joypad.sv | 150 +++++++++++++++
 tb/tb_periph_joypad.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_joypad_pkg.sv
// Shared types and constants for the NES-style controller port block.
// Bus widths, register offsets and capture FSM state encoding.
package periph_joypad_pkg;

  localparam int PERIPH_N = 16;
  localparam int DATA_N = 8;
  localparam int JOYPAD_BITS = 8;

  localparam logic JOYPAD_REG_P1 = 1'b0;
  localparam logic JOYPAD_REG_P2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HI,
    CLK_LO,
    DONE
  } joypad_state_t;

endpackage

// File: rtl/periph_joypad_if.sv
// Peripheral bus access signals for the controller ports.
// The shared data lines travel as a separate tristate port.
interface periph_joypad_if;
  import periph_joypad_pkg::*;

  logic sel;
  logic we;
  logic [PERIPH_N-1:0] addr;

  modport master (output sel, output we, output addr);
  modport slave (input sel, input we, input addr);

endinterface

// File: rtl/periph_joypad_shift.sv
// One controller port: capture register, serial read register
// with fill, and the bit-0 value presented to the CPU.
module periph_joypad_shift
  import periph_joypad_pkg::*;
#(
  parameter logic FILL_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cap_we,
  input  logic [2:0] cap_idx,
  input  logic       cap_bit,
  input  logic       load,
  input  logic       shift,
  input  logic       strobe,
  output logic       q0
);

  logic [JOYPAD_BITS-1:0] cap;
  logic [JOYPAD_BITS-1:0] sh;
  logic last0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap <= '0;
      sh <= '0;
      last0 <= 1'b0;
    end else begin
      if (cap_we)
        cap[cap_idx] <= cap_bit;
      // A fresh capture overrides a coincident read shift
      if (load) begin
        sh <= cap;
        last0 <= cap[0];
      end else if (shift) begin
        sh <= {FILL_BIT, sh[JOYPAD_BITS-1:1]};
      end
    end
  end

  assign q0 = strobe ? last0 : sh[0];

endmodule

// File: rtl/periph_joypad.sv
// Controller port responder for $4016/$4017 with serial pad capture.
// Define JOYPAD_SYNC_EN to add a 2-FF synchronizer on pad_data.
module periph_joypad
  import periph_joypad_pkg::*;
#(
  parameter int   CLK_DIV  = 12,
  parameter logic FILL_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  periph_joypad_if.slave    bus,
  inout  wire  [DATA_N-1:0] data,
  output logic              pad_latch,
  output logic [1:0]        pad_clk,
  input  logic [1:0]        pad_data,
  output logic              busy
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] LAST_D = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_L = CW'(2 * CLK_DIV - 1);

  joypad_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic rd, wr, rd_q, port_q, ae;
  logic strobe, strobe_q, strobe_fall;
  logic cap_we, load, rbit;
  logic [2:0] cap_idx;
  logic [1:0] pad_s, q0, shift_en;
  logic unused;

  assign rd = bus.sel & ~bus.we;
  assign wr = bus.sel & bus.we;
  assign ae = rd_q & ~rd;
  assign strobe_fall = strobe_q & ~strobe;
  assign unused = ^{bus.addr[PERIPH_N-1:1], data[DATA_N-1:1]};

`ifdef JOYPAD_SYNC_EN
  logic [1:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end
  assign pad_s = sync2;
`else
  assign pad_s = pad_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0;
      port_q <= 1'b0;
      strobe <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      rd_q <= rd;
      strobe_q <= strobe;
      if (rd)
        port_q <= bus.addr[0];
      if (wr && bus.addr[0] == JOYPAD_REG_P1)
        strobe <= data[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      pad_latch <= 1'b0;
      pad_clk <= 2'b00;
      busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (strobe || strobe_fall) begin
          state <= LATCH;
          cnt <= '0;
          pad_latch <= 1'b1;
          busy <= 1'b1;
        end
        LATCH: if (cnt == LAST_L) begin
          state <= SETTLE;
          cnt <= '0;
          pad_latch <= 1'b0;
        end else cnt <= cnt + CW'(1);
        SETTLE: if (cnt == LAST_D) begin
          state <= CLK_HI;
          cnt <= '0;
          idx <= 3'd1;
          pad_clk <= 2'b11;
        end else cnt <= cnt + CW'(1);
        CLK_HI: if (cnt == LAST_D) begin
          state <= CLK_LO;
          cnt <= '0;
          pad_clk <= 2'b00;
        end else cnt <= cnt + CW'(1);
        CLK_LO: if (cnt == LAST_D) begin
          cnt <= '0;
          if (idx == 3'd7) begin
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
            state <= CLK_HI;
            pad_clk <= 2'b11;
          end
        end else cnt <= cnt + CW'(1);
        DONE: if (strobe) begin
          state <= LATCH;
          pad_latch <= 1'b1;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign cap_we = (state == SETTLE || state == CLK_LO) && cnt == LAST_D;
  assign cap_idx = (state == SETTLE) ? 3'd0 : idx;
  assign load = (state == DONE);

  for (genvar p = 0; p < 2; p++) begin : g_pad
    assign shift_en[p] = ae & ~strobe & (port_q == 1'(p));
    periph_joypad_shift #(.FILL_BIT(FILL_BIT)) u_shift (
      .clk     (clk),
      .reset   (reset),
      .cap_we  (cap_we),
      .cap_idx (cap_idx),
      .cap_bit (~pad_s[p]),
      .load    (load),
      .shift   (shift_en[p]),
      .strobe  (strobe),
      .q0      (q0[p])
    );
  end

  assign rbit = (bus.addr[0] == JOYPAD_REG_P2) ? q0[1] : q0[0];
  assign data = rd ? {{(DATA_N-1){1'b0}}, rbit} : {DATA_N{1'bz}};

endmodule

// File: tb/tb_periph_joypad.sv
// Bench for periph_joypad: pad models, random button patterns and a
// read-order reference model of the two serial read registers.
module tb_periph_joypad;
  import periph_joypad_pkg::*;

  localparam int D = 12;
  localparam logic FILL = 1'b1;
  localparam int CAP_LEN = 17 * D + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_joypad_if bus();
  wire [DATA_N-1:0] data;
  logic drv_en = 1'b0;
  logic [DATA_N-1:0] drv_val = '0;
  assign data = drv_en ? drv_val : {DATA_N{1'bz}};

  logic pad_latch;
  logic [1:0] pad_clk;
  logic [1:0] pad_data;
  logic busy;

  periph_joypad #(.CLK_DIV(D), .FILL_BIT(FILL)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .data      (data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .busy      (busy)
  );

  // Controllers: latch reloads, each pad_clk rise advances a button
  logic [7:0] btn [2];
  logic [3:0] pcnt [2];
  logic [1:0] pclk_d;

  initial begin
    pcnt[0] = 4'd8;
    pcnt[1] = 4'd8;
    pclk_d = 2'b00;
  end

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (pad_latch)
        pcnt[p] <= 4'd0;
      else if (pad_clk[p] && !pclk_d[p] && pcnt[p] < 4'd8)
        pcnt[p] <= pcnt[p] + 4'd1;
    end
    pclk_d <= pad_clk;
  end

  always_comb begin
    pad_data = 2'b11;
    for (int p = 0; p < 2; p++)
      if (pcnt[p] < 4'd8)
        pad_data[p] = ~btn[p][pcnt[p][2:0]];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each port holds its last 8 buttons and a read count
  logic [7:0] mreg [2];
  int mcnt [2];
  logic mlast [2];
  logic mstrobe;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mreg[p] = 8'h00;
      mcnt[p] = 0;
      mlast[p] = 1'b0;
    end
    mstrobe = 1'b0;
  endtask

  task automatic model_capture();
    for (int p = 0; p < 2; p++) begin
      mreg[p] = btn[p];
      mcnt[p] = 0;
      mlast[p] = btn[p][0];
    end
  endtask

  task automatic bus_wr(input int a, input logic [7:0] v);
    bus.sel = 1'b1;
    bus.we = 1'b1;
    bus.addr = PERIPH_N'(a);
    drv_val = v;
    drv_en = 1'b1;
    @(posedge clk); #1;
    bus.sel = 1'b0;
    bus.we = 1'b0;
    drv_en = 1'b0;
    if (a == 0)
      mstrobe = v[0];
  endtask

  task automatic bus_rd(input int p, input int hold, input string tag);
    logic e;
    if (mstrobe) begin
      e = mlast[p];
    end else if (mcnt[p] < 8) begin
      e = mreg[p][mcnt[p]];
      mcnt[p]++;
    end else begin
      e = FILL;
    end
    bus.sel = 1'b1;
    bus.we = 1'b0;
    bus.addr = PERIPH_N'(p);
    for (int i = 0; i < hold; i++) begin
      #2;
      chk(tag, 32'(data), {31'd0, e});
      @(posedge clk); #1;
    end
    bus.sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy)
      chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_latch(output int cyc);
    logic prev;
    prev = pad_latch;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (pad_latch && !prev)
        return;
      prev = pad_latch;
    end
    chk("latch_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture();
    bus_wr(0, 8'h01);
    bus_wr(0, 8'h00);
    wait_idle("cap_timeout");
    model_capture();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    logic prev;
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    btn[0] = 8'h00;
    btn[1] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_padclk", 32'(pad_clk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus_rd(0, 1, "rst_rd_p0");
    bus_rd(1, 1, "rst_rd_p1");

    // A and Right pressed on pad 1
    btn[0] = 8'h81;
    btn[1] = 8'($urandom_range(0, 255));
    bus_wr(0, 8'h01);
    bus_wr(0, 8'h00);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_len", 32'(n), 32'(CAP_LEN));
    model_capture();
    for (int i = 0; i < 10; i++)
      bus_rd(0, 1, "dir_rd");

    repeat (6) begin
      btn[0] = 8'($urandom_range(0, 255));
      btn[1] = 8'($urandom_range(0, 255));
      capture();
      repeat (14)
        bus_rd(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), "rnd_rd");
    end

    // Continuous strobe: reads return A, latch repeats every capture
    btn[0] = 8'($urandom_range(0, 255)) | 8'h01;
    btn[1] = 8'($urandom_range(0, 255));
    bus_wr(0, 8'h01);
    wait_latch(cyc);
    wait_latch(cyc);
    chk("latch_period", 32'(cyc), 32'(CAP_LEN));
    model_capture();
    bus_rd(0, 1, "stb_rd_p0");
    bus_rd(0, 3, "stb_rd_p0_hold");
    bus_rd(1, 2, "stb_rd_p1");
    bus_rd(0, 1, "stb_rd_p0_again");
    bus_wr(0, 8'h00);
    wait_idle("stb_timeout");
    model_capture();
    bus_wr(1, 8'h01);
    repeat (3) @(posedge clk);
    #1 chk("wr_off1_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 9; i++)
      bus_rd(0, 1, "stb_off_p0");
    bus_rd(1, 2, "stb_off_p1");

    // Reset while pad clock is high for bit 4
    btn[0] = 8'($urandom_range(0, 255));
    btn[1] = 8'($urandom_range(0, 255));
    bus_wr(0, 8'h01);
    bus_wr(0, 8'h00);
    n = 0;
    prev = pad_clk[0];
    for (int i = 0; i < 1000 && n < 4; i++) begin
      @(posedge clk); #1;
      if (pad_clk[0] && !prev)
        n++;
      prev = pad_clk[0];
    end
    chk("rst_mid_reach", 32'(n), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_latch", 32'(pad_latch), 32'd0);
    chk("rst_mid_padclk", 32'(pad_clk), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    bus_rd(0, 1, "rst_mid_rd_p0");
    bus_rd(1, 1, "rst_mid_rd_p1");
    btn[0] = 8'($urandom_range(0, 255));
    btn[1] = 8'($urandom_range(0, 255));
    capture();
    for (int i = 0; i < 8; i++) begin
      bus_rd(0, 1, "post_rst_p0");
      bus_rd(1, 1, "post_rst_p1");
    end

    // Access end lands on the DONE cycle
    btn[0] = (8'($urandom_range(0, 255)) & 8'h7e) | 8'h01;
    btn[1] = 8'($urandom_range(0, 255));
    bus_rd(0, 1, "col_pre");
    bus_wr(0, 8'h01);
    bus_wr(0, 8'h00);
    chk("col_latch", 32'(pad_latch), 32'd1);
    repeat (CAP_LEN - 2) @(posedge clk);
    #1;
    bus.sel = 1'b1;
    bus.we = 1'b0;
    bus.addr = PERIPH_N'(0);
    @(posedge clk); #1;
    bus.sel = 1'b0;
    @(posedge clk); #1;
    chk("col_idle", 32'(busy), 32'd0);
    model_capture();
    for (int i = 0; i < 9; i++)
      bus_rd(0, 1, "col_rd_p0");
    bus_rd(1, 1, "col_rd_p1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
